ps2_host_tx: RTL and testbench

// Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse or keyboard.

---
 rtl/ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives the open-drain enables for PS2_CLK/PS2_DAT through inhibit,
// request-to-send, 8 data bits (LSB first), odd parity, stop and device ACK.
// Optional build macro: PS2_TX_RETRY_EN -- on NACK/timeout the same byte is
// resent up to MAX_RETRIES extra times before tx_error is reported.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE,
    S_FAIL
  } state_t;

  state_t           state_q, state_n;
  logic [INH_W-1:0] inh_q, inh_n;
  logic [TO_W-1:0]  to_q, to_n;
  logic [2:0]       idx_q, idx_n;
  logic [7:0]       byte_q, byte_n;
  logic             par_q, par_n;
  logic             clk_oe_q, clk_oe_n;
  logic             dat_oe_q, dat_oe_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             to_run;

`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  logic [RETRY_W-1:0] retry_q, retry_n;
`endif

  logic clk_meta, clk_sync, clk_prev;
  logic dat_meta, dat_sync;
  logic fe;

  // Two-flop synchronizers for both pins plus a delayed clock for edge detect.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  assign fe = clk_prev & ~clk_sync;

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      state_q  <= S_IDLE;
      inh_q    <= '0;
      to_q     <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      par_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_n;
      inh_q    <= inh_n;
      to_q     <= to_n;
      idx_q    <= idx_n;
      byte_q   <= byte_n;
      par_q    <= par_n;
      clk_oe_q <= clk_oe_n;
      dat_oe_q <= dat_oe_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= retry_n;
`endif
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_n  = state_q;
    inh_n    = inh_q;
    to_n     = to_q;
    idx_n    = idx_q;
    byte_n   = byte_q;
    par_n    = par_q;
    clk_oe_n = clk_oe_q;
    dat_oe_n = dat_oe_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    to_run   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n  = retry_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (tx_start) begin
          byte_n   = tx_data;
          par_n    = ~^tx_data;
          busy_n   = 1'b1;
          inh_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n  = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          dat_oe_n = 1'b1;
          to_n     = '0;
          state_n  = S_RTS;
        end else begin
          inh_n = inh_q + 1'b1;
        end
      end
      S_RTS: begin
        clk_oe_n = 1'b0;
        idx_n    = '0;
        state_n  = S_DATA;
      end
      S_DATA: begin
        to_run = 1'b1;
        if (fe) begin
          dat_oe_n = ~byte_q[idx_q];
          idx_n    = idx_q + 3'd1;
          if (idx_q == 3'd7) state_n = S_PARITY;
        end
      end
      S_PARITY: begin
        to_run = 1'b1;
        if (fe) begin
          dat_oe_n = ~par_q;
          state_n  = S_STOP;
        end
      end
      S_STOP: begin
        to_run = 1'b1;
        if (fe) begin
          dat_oe_n = 1'b0;
          state_n  = S_ACK;
        end
      end
      S_ACK: begin
        to_run = 1'b1;
        if (fe) state_n = dat_sync ? S_FAIL : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        to_run = 1'b1;
        if (clk_sync && dat_sync) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_FAIL: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
        if (retry_q < RETRY_LIMIT) begin
          retry_n  = retry_q + 1'b1;
          inh_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = S_INHIBIT;
        end else begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
`else
        err_n   = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase

    // Watchdog between device clock edges; a normal transition taken in the
    // same cycle (e.g. WAIT_IDLE completing) wins over the timeout.
    if (to_run) begin
      if (fe) begin
        to_n = '0;
      end else if (to_q == TO_LAST) begin
        if (state_n == state_q) begin
          state_n  = S_FAIL;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
        end
      end else begin
        to_n = to_q + 1'b1;
      end
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH     = 6000;
  localparam int unsigned TO      = 2000;
  localparam int unsigned RETRIES = 2;
  localparam int unsigned HALF    = 15;
  localparam int unsigned BUDGET  = (RETRIES + 1) * (INH + TO + 600);

  logic       CLOCK_50 = 1'b0;
  logic       KEY      = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (RETRIES)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY       (KEY),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;

  typedef struct {
    bit          is_err;
    int          nfr;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] obs_q[$];
  exp_t        mon_e;
  logic [10:0] dev_frame;

  typedef enum int {DEV_ACK, DEV_NACK, DEV_SILENT} dev_mode_t;
  dev_mode_t dev_mode   = DEV_ACK;
  int        dev_fe     = 0;
  bit        dev_active = 1'b0;
  bit        prev_pulse = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endfunction

  // Device model: answers a request-to-send with 11 clocks, samples host data
  // on its rising clock edges (start bit before the first clock), ACKs at fe #11.
  initial begin : device
    forever begin
      @(negedge CLOCK_50);
      if (dev_mode != DEV_SILENT && KEY && !ps2_clk_oe && ps2_dat_oe) begin
        dev_active = 1'b1;
        dev_fe     = 0;
        repeat (2 * HALF) @(negedge CLOCK_50);
        dev_frame[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
          dev_clk = 1'b0;
          dev_fe  = k;
          repeat (HALF) @(negedge CLOCK_50);
          dev_clk = 1'b1;
          dev_frame[k] = ps2_dat_in;
          repeat (HALF) @(negedge CLOCK_50);
        end
        obs_q.push_back(dev_frame);
        if (dev_mode == DEV_ACK) dev_dat = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        dev_clk = 1'b0;
        dev_fe  = 11;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        dev_dat    = 1'b1;
        dev_active = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every done/error pulse pops one expectation and the
  // frames the device observed for it.
  always @(negedge CLOCK_50) begin
    if (prev_pulse) chk("pulse_width", {tx_done, tx_error}, 2'b00);
    prev_pulse <= KEY && (tx_done || tx_error);
    if (KEY && (tx_done || tx_error)) begin
      pulse_count++;
      chk("lines_released_at_end", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      chk("busy_low_at_end", tx_busy, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {tx_done, tx_error}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        chk("end_kind_done_error", {tx_done, tx_error}, mon_e.is_err ? 2'b01 : 2'b10);
        for (int i = 0; i < mon_e.nfr; i++) begin
          if (obs_q.size() > 0) chk("device_frame", obs_q.pop_front(), mon_e.frame);
          else chk("frame_count", i, mon_e.nfr);
        end
        chk("extra_frames", obs_q.size(), 0);
      end
    end
  end

  task automatic issue(input logic [7:0] b, input bit expect_pulse, input bit is_err,
                       input int nfr, input logic [10:0] frame);
    exp_t e;
    e.is_err = is_err;
    e.nfr    = nfr;
    e.frame  = frame;
    if (expect_pulse) exp_q.push_back(e);
    @(negedge CLOCK_50);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge CLOCK_50);
    tx_start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < int'(BUDGET)) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_end_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic wait_dev_fe(input int k);
    int n = 0;
    while (dev_fe != k && n < int'(INH + 1000)) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("device_reached_edge", dev_fe, k);
  endtask

  initial begin : stim
    int n;
    int pc;
    bit seen_oe;
    int nack_frames;

`ifdef PS2_TX_RETRY_EN
    nack_frames = 1 + RETRIES;
`else
    nack_frames = 1;
`endif

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("reset_clk_oe", ps2_clk_oe, 1'b0);
    chk("reset_dat_oe", ps2_dat_oe, 1'b0);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_done", tx_done, 1'b0);
    chk("reset_error", tx_error, 1'b0);
    KEY = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // 1: 0xF4 with inhibit/RTS timing
    issue(8'hF4, 1'b1, 1'b0, 1, 11'h5E8);
    chk("busy_after_accept", tx_busy, 1'b1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < int'(INH + 100)) begin
      n++;
      @(negedge CLOCK_50);
    end
    chk("inhibit_cycles", n, INH);
    chk("rts_both_low", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
    @(negedge CLOCK_50);
    chk("clk_released_dat_held", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    wait_end("f4");

    // 2: 0xED, parity bit 1
    issue(8'hED, 1'b1, 1'b0, 1, 11'h7DA);
    wait_end("ed");

    // 3: silent device -> timeout
    dev_mode = DEV_SILENT;
    issue(8'hF4, 1'b1, 1'b1, 0, 11'h000);
    n = 0;
    for (int i = 0; i < int'(BUDGET); i++) begin
      @(negedge CLOCK_50);
      if (tx_error) break;
      n = ps2_clk_oe ? 0 : n + 1;
    end
    chk_range("timeout_latency", n, TO - 4, TO + 4);
    wait_end("timeout");
    dev_mode = DEV_ACK;

    // 4: persistent NACK
    dev_mode = DEV_NACK;
    issue(8'hFF, 1'b1, 1'b1, nack_frames, 11'h7FE);
    wait_end("nack");
    dev_mode = DEV_ACK;

    // 5: reset during data bit 4, then a clean frame
    issue(8'hF4, 1'b0, 1'b0, 0, 11'h000);
    wait_dev_fe(5);
    repeat (3) @(negedge CLOCK_50);
    pc = pulse_count;
    KEY = 1'b0;
    @(negedge CLOCK_50);
    chk("midreset_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("midreset_busy", tx_busy, 1'b0);
    chk("midreset_pulses", {tx_done, tx_error}, 2'b00);
    repeat (2) @(negedge CLOCK_50);
    KEY = 1'b1;
    seen_oe = 1'b0;
    n = 0;
    while (dev_active && n < 2000) begin
      @(negedge CLOCK_50);
      if (ps2_clk_oe || ps2_dat_oe) seen_oe = 1'b1;
      n++;
    end
    chk("idle_lines_untouched", seen_oe, 1'b0);
    repeat (50) @(negedge CLOCK_50);
    chk("no_pulse_after_reset", pulse_count, pc);
    obs_q.delete();
    issue(8'hF4, 1'b1, 1'b0, 1, 11'h5E8);
    wait_end("after_reset");

    // 6: re-pulse tx_start with 0x00 mid-frame
    issue(8'hAA, 1'b1, 1'b0, 1, 11'h754);
    wait_dev_fe(3);
    pc = pulse_count;
    @(negedge CLOCK_50);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge CLOCK_50);
    tx_start = 1'b0;
    wait_end("restart_ignored");
    repeat (50) @(negedge CLOCK_50);
    chk("single_done", pulse_count - pc, 1);
    chk("idle_after_all", tx_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
